// File: rtl/irq_capture_pkg.sv
// Shared defaults and mode encodings for the interrupt capture block.
package irq_capture_pkg;

  localparam int DEF_NUM_IRQ     = 8;
  localparam int DEF_ID_W        = $clog2(DEF_NUM_IRQ);
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } mode_e;

  typedef enum logic {
    POL_LOW  = 1'b0,
    POL_HIGH = 1'b1
  } pol_e;

endpackage

// File: rtl/irq_sync.sv
// One multi-flop synchronizer chain for a single asynchronous interrupt line.
module irq_sync
  import irq_capture_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic aclk,
  input  logic areset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/irq_capture.sv
// Per-line interrupt capture: synchronize, apply polarity, detect edges or
// follow levels, hold pending until acknowledged, flag overflows.
module irq_capture
  import irq_capture_pkg::*;
#(
  parameter int NUM_IRQ     = DEF_NUM_IRQ,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [NUM_IRQ-1:0]         irq_in,
  input  logic [NUM_IRQ-1:0]         cfg_enable,
  input  logic [NUM_IRQ-1:0]         cfg_edge,
  input  logic [NUM_IRQ-1:0]         cfg_pol,
  input  logic                       ack_valid,
  input  logic [$clog2(NUM_IRQ)-1:0] ack_id,
  output logic [NUM_IRQ-1:0]         pend_out,
  output logic                       irq_any,
  output logic [NUM_IRQ-1:0]         ovf_out,
  input  logic [NUM_IRQ-1:0]         ovf_clr,
  output logic                       ack_err
);

  logic [NUM_IRQ-1:0] sync_out;
  logic [NUM_IRQ-1:0] act;
  logic [NUM_IRQ-1:0] act_d;
  logic [NUM_IRQ-1:0] edge_hit;
  logic [NUM_IRQ-1:0] edge_d;
  logic [NUM_IRQ-1:0] mode_chg;
  logic [NUM_IRQ-1:0] ack_hit;
  logic [NUM_IRQ-1:0] pend_nxt;
  logic [NUM_IRQ-1:0] ovf_set;
  logic               ack_ok;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .aclk   (aclk),
      .areset (areset),
      .d      (irq_in[g]),
      .q      (sync_out[g])
    );
  end

  assign act      = ~(sync_out ^ cfg_pol);
  assign edge_hit = act & ~act_d;
  assign mode_chg = cfg_edge ^ edge_d;

  // An acknowledge only counts against an edge-mode line that is pending.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_hit[i] = ack_valid && (int'(ack_id) == i) &&
                   (mode_e'(cfg_edge[i]) == MODE_EDGE) && pend_out[i];
    end
  end

  assign ack_ok = |ack_hit;

  always_comb begin
    pend_nxt = '0;
    ovf_set  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (mode_chg[i]) begin
        pend_nxt[i] = 1'b0;
      end else if (mode_e'(cfg_edge[i]) == MODE_EDGE) begin
        if (!cfg_enable[i]) begin
          pend_nxt[i] = 1'b0;
        end else if (edge_hit[i]) begin
          // A fresh edge beats a same-cycle ack and is not an overflow.
          pend_nxt[i] = 1'b1;
          ovf_set[i]  = pend_out[i] & ~ack_hit[i];
        end else begin
          pend_nxt[i] = pend_out[i] & ~ack_hit[i];
        end
      end else begin
        pend_nxt[i] = act[i] & cfg_enable[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge aclk) begin
    if (areset) begin
      act_d    <= '0;
      // NOTE: edge_d tracks config, so reset loads it rather than clearing it;
      // that keeps reset from looking like a mode change.
      edge_d   <= cfg_edge;
      pend_out <= '0;
      ovf_out  <= '0;
      ack_err  <= 1'b0;
    end else begin
      act_d    <= act;
      edge_d   <= cfg_edge;
      pend_out <= pend_nxt;
      ovf_out  <= (ovf_out & ~ovf_clr) | ovf_set;
      ack_err  <= ack_valid & ~ack_ok;
    end
  end

  assign irq_any = |pend_out;

endmodule

// File: tb/tb_irq_capture.sv
// Scoreboard bench for irq_capture: expectations are queued with a due cycle
// when stimulus is applied and compared when that cycle is reached.
module tb_irq_capture;
  import irq_capture_pkg::*;

  localparam int N = DEF_NUM_IRQ;

  typedef enum int {SEL_PEND, SEL_OVF, SEL_ERR, SEL_ANY} sel_e;

  typedef struct {
    int           due;
    string        tag;
    sel_e         sel;
    logic [N-1:0] mask;
    logic [N-1:0] exp;
  } exp_t;

  logic                aclk = 1'b0;
  logic                areset;
  logic [N-1:0]        irq_in, cfg_enable, cfg_edge, cfg_pol;
  logic                ack_valid;
  logic [DEF_ID_W-1:0] ack_id;
  logic [N-1:0]        pend_out, ovf_out, ovf_clr;
  logic                irq_any, ack_err;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  irq_capture #(.NUM_IRQ(N), .SYNC_STAGES(DEF_SYNC_STAGES)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .irq_in     (irq_in),
    .cfg_enable (cfg_enable),
    .cfg_edge   (cfg_edge),
    .cfg_pol    (cfg_pol),
    .ack_valid  (ack_valid),
    .ack_id     (ack_id),
    .pend_out   (pend_out),
    .irq_any    (irq_any),
    .ovf_out    (ovf_out),
    .ovf_clr    (ovf_clr),
    .ack_err    (ack_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input string tag, input sel_e sel, input logic [N-1:0] mask,
                           input logic [N-1:0] val, input int dly);
    exp_t e;
    e.due  = cyc + dly;
    e.tag  = tag;
    e.sel  = sel;
    e.mask = mask;
    e.exp  = val & mask;
    sb.push_back(e);
  endtask

  // Advance n clocks; outputs are sampled 1 time unit after each rising edge.
  task automatic steps(input int n);
    logic [N-1:0] got;
    for (int k = 0; k < n; k++) begin
      @(posedge aclk);
      #1;
      cyc++;
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].due == cyc) begin
          case (sb[j].sel)
            SEL_PEND: got = pend_out & sb[j].mask;
            SEL_OVF:  got = ovf_out & sb[j].mask;
            SEL_ERR:  got = N'(ack_err);
            default:  got = N'(irq_any);
          endcase
          check(sb[j].tag, got, sb[j].exp);
          sb.delete(j);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    areset     = 1'b1;
    irq_in     = '0;
    cfg_enable = '1;
    cfg_edge   = '1;
    cfg_pol    = '1;
    ack_valid  = 1'b0;
    ack_id     = '0;
    ovf_clr    = '0;

    expect_at("rst_pend", SEL_PEND, '1, '0, 1);
    expect_at("rst_ovf",  SEL_OVF,  '1, '0, 1);
    expect_at("rst_err",  SEL_ERR,  8'h01, '0, 1);
    expect_at("rst_any",  SEL_ANY,  8'h01, '0, 1);
    steps(3);
    areset = 1'b0;
    expect_at("idle_pend", SEL_PEND, '1, '0, 3);
    steps(4);

    // Edge capture latency on line 3
    irq_in[3] = 1'b1;
    expect_at("lat_e1", SEL_PEND, '1, 8'h00, 1);
    expect_at("lat_e2", SEL_PEND, '1, 8'h00, 2);
    expect_at("lat_e3", SEL_PEND, '1, 8'h08, 3);
    expect_at("any_e2", SEL_ANY, 8'h01, 8'h00, 2);
    expect_at("any_e3", SEL_ANY, 8'h01, 8'h01, 3);
    steps(1);
    irq_in[3] = 1'b0;
    steps(5);

    // Second edge before ack -> overflow; then ack and clear
    irq_in[3] = 1'b1;
    expect_at("ovf_pre",  SEL_OVF,  '1, 8'h00, 2);
    expect_at("ovf_set",  SEL_OVF,  '1, 8'h08, 3);
    expect_at("ovf_pend", SEL_PEND, '1, 8'h08, 3);
    steps(1);
    irq_in[3] = 1'b0;
    steps(4);
    ack_valid = 1'b1;
    ack_id    = DEF_ID_W'(3);
    expect_at("ack3_pend", SEL_PEND, '1, 8'h00, 1);
    expect_at("ack3_err",  SEL_ERR,  8'h01, 8'h00, 1);
    expect_at("ack3_ovf",  SEL_OVF,  '1, 8'h08, 1);
    steps(1);
    ack_valid = 1'b0;
    steps(2);
    ovf_clr = 8'h08;
    expect_at("ovf_clr", SEL_OVF, '1, 8'h00, 1);
    steps(1);
    ovf_clr = '0;
    steps(2);

    // Ack of line 1 in the same cycle as a new edge on line 1
    irq_in[1] = 1'b1;
    expect_at("l1_cap", SEL_PEND, '1, 8'h02, 3);
    steps(1);
    irq_in[1] = 1'b0;
    steps(5);
    irq_in[1] = 1'b1;
    steps(1);
    irq_in[1] = 1'b0;
    steps(1);
    ack_valid = 1'b1;
    ack_id    = DEF_ID_W'(1);
    expect_at("sim_pend", SEL_PEND, 8'h02, 8'h02, 1);
    expect_at("sim_ovf",  SEL_OVF,  8'h02, 8'h00, 1);
    expect_at("sim_err",  SEL_ERR,  8'h01, 8'h00, 1);
    expect_at("sim_hold", SEL_PEND, 8'h02, 8'h02, 3);
    steps(1);
    ack_valid = 1'b0;
    steps(3);
    ack_valid = 1'b1;
    expect_at("l1_clr", SEL_PEND, '1, 8'h00, 1);
    steps(1);
    ack_valid = 1'b0;
    steps(1);

    // Line 4 as active-low level interrupt
    cfg_enable[4] = 1'b0;
    irq_in[4]     = 1'b1;
    steps(4);
    cfg_pol[4]  = 1'b0;
    cfg_edge[4] = 1'b0;
    steps(4);
    cfg_enable[4] = 1'b1;
    expect_at("lvl_idle", SEL_PEND, 8'h10, 8'h00, 2);
    steps(3);
    irq_in[4] = 1'b0;
    for (int k = 1; k <= 13; k++)
      expect_at("lvl_pend", SEL_PEND, 8'h10, (k >= 3 && k <= 12) ? 8'h10 : 8'h00, k);
    steps(5);
    ack_valid = 1'b1;
    ack_id    = DEF_ID_W'(4);
    expect_at("lvl_err1", SEL_ERR, 8'h01, 8'h01, 1);
    expect_at("lvl_err0", SEL_ERR, 8'h01, 8'h00, 2);
    steps(1);
    ack_valid = 1'b0;
    steps(4);
    irq_in[4] = 1'b1;
    steps(4);
    cfg_enable[4] = 1'b0;
    steps(2);

    // Ack of a non-pending line, then disable a pending line
    ack_valid = 1'b1;
    ack_id    = DEF_ID_W'(0);
    expect_at("inv_err1", SEL_ERR,  8'h01, 8'h01, 1);
    expect_at("inv_err0", SEL_ERR,  8'h01, 8'h00, 2);
    expect_at("inv_pend", SEL_PEND, '1, 8'h00, 1);
    steps(1);
    ack_valid = 1'b0;
    steps(2);
    irq_in[5] = 1'b1;
    expect_at("l5_cap", SEL_PEND, '1, 8'h20, 3);
    steps(1);
    irq_in[5] = 1'b0;
    steps(3);
    cfg_enable[5] = 1'b0;
    expect_at("dis_pend", SEL_PEND, '1, 8'h00, 1);
    expect_at("dis_ovf",  SEL_OVF,  '1, 8'h00, 1);
    steps(1);
    cfg_enable[5] = 1'b1;
    steps(2);

    // Build pend=0x0D, ovf=0x01, then reset with line 2 held through release
    irq_in[0] = 1'b1;
    irq_in[2] = 1'b1;
    irq_in[3] = 1'b1;
    steps(1);
    irq_in[0] = 1'b0;
    irq_in[2] = 1'b0;
    irq_in[3] = 1'b0;
    steps(5);
    irq_in[0] = 1'b1;
    steps(1);
    irq_in[0] = 1'b0;
    expect_at("pre_pend", SEL_PEND, '1, 8'h0D, 3);
    expect_at("pre_ovf",  SEL_OVF,  '1, 8'h01, 3);
    steps(4);
    areset    = 1'b1;
    irq_in[2] = 1'b1;
    expect_at("rst2_pend", SEL_PEND, '1, 8'h00, 1);
    expect_at("rst2_ovf",  SEL_OVF,  '1, 8'h00, 1);
    expect_at("rst2_err",  SEL_ERR,  8'h01, 8'h00, 1);
    expect_at("rst2_any",  SEL_ANY,  8'h01, 8'h00, 1);
    expect_at("rst2_hold", SEL_PEND, '1, 8'h00, 3);
    steps(3);
    areset = 1'b0;
    expect_at("rel_p1",  SEL_PEND, '1, 8'h00, 1);
    expect_at("rel_p2",  SEL_PEND, '1, 8'h00, 2);
    expect_at("rel_p3",  SEL_PEND, '1, 8'h04, 3);
    expect_at("rel_p6",  SEL_PEND, '1, 8'h04, 6);
    expect_at("rel_ovf", SEL_OVF,  '1, 8'h00, 6);
    steps(7);
    ack_valid = 1'b1;
    ack_id    = DEF_ID_W'(2);
    expect_at("rel_ack",  SEL_PEND, '1, 8'h00, 1);
    expect_at("rel_once", SEL_PEND, '1, 8'h00, 4);
    steps(1);
    ack_valid = 1'b0;
    steps(5);
    irq_in[2] = 1'b0;

    for (int k = 0; k < 20 && sb.size() > 0; k++) steps(1);
    check("sb_drain", N'(sb.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
